// File: rtl/pic16_pkg.sv
// Shared PIC16F core constants and the call-stack operation encoding.
package pic16_pkg;

  localparam int PC_W        = 13;
  localparam int STACK_DEPTH = 8;
  localparam int STACK_PTR_W = 3;

  typedef enum logic [1:0] {
    STK_HOLD    = 2'b00,
    STK_PUSH    = 2'b01,
    STK_POP     = 2'b10,
    STK_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e stack_op(input logic push, input logic pop);
    return stack_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port,
// synchronous clear of every entry.
module stack_regfile #(
  parameter int PC_W  = pic16_pkg::PC_W,
  parameter int DEPTH = pic16_pkg::STACK_DEPTH,
  parameter int PTR_W = pic16_pkg::STACK_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [PC_W-1:0]  wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [PC_W-1:0]  rdata_o
);

  logic [PC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// PIC16F circular return-address stack: sp/depth control, push/pop arbitration
// and sticky overflow/underflow debug flags.
module call_stack #(
  parameter int PC_W  = pic16_pkg::PC_W,
  parameter int DEPTH = pic16_pkg::STACK_DEPTH,
  parameter int PTR_W = pic16_pkg::STACK_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en,
  input  logic [PC_W-1:0]  push_data,
  input  logic             pop_en,
  input  logic             flags_clr,
  output logic [PC_W-1:0]  tos_out,
  output logic [PTR_W:0]   depth,
  output logic             ovf_flag,
  output logic             unf_flag
);

  import pic16_pkg::*;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] waddr;
  logic             we;
  stack_op_e        op;

  assign op      = stack_op(push_en, pop_en);
  assign top_idx = sp_q - 1'b1;

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = flags_clr ? 1'b0 : ovf_q;
    unf_d   = flags_clr ? 1'b0 : unf_q;
    we      = 1'b0;
    waddr   = sp_q;
    unique case (op)
      STK_PUSH: begin
        we   = 1'b1;
        sp_d = sp_q + 1'b1;
        if (depth_q == FULL) ovf_d = 1'b1;
        else depth_d = depth_q + 1'b1;
      end
      STK_POP: begin
        sp_d = sp_q - 1'b1;
        if (depth_q == '0) unf_d = 1'b1;
        else depth_d = depth_q - 1'b1;
      end
      // Tail call: overwrite the top in place, even on an empty stack.
      STK_REPLACE: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_regfile #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_data),
    .raddr_i (top_idx),
    .rdata_o (tos_out)
  );

  assign depth    = depth_q;
  assign ovf_flag = ovf_q;
  assign unf_flag = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed and randomized checks of call_stack against hand-computed values
// and a small circular-stack reference model.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_en;
  logic [12:0] push_data;
  logic        pop_en;
  logic        flags_clr;
  logic [12:0] tos_out;
  logic [3:0]  depth;
  logic        ovf_flag;
  logic        unf_flag;

  int passed = 0;
  int total  = 0;

  // reference model
  logic [12:0] m_mem [8];
  int          m_sp, m_dep;
  logic        m_ovf, m_unf;

  call_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push_en   (push_en),
    .push_data (push_data),
    .pop_en    (pop_en),
    .flags_clr (flags_clr),
    .tos_out   (tos_out),
    .depth     (depth),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; push_en = 1'b0; pop_en = 1'b0; flags_clr = 1'b0; push_data = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic push(input logic [12:0] d);
    idle(); push_en = 1'b1; push_data = d; cyc(); idle();
  endtask

  task automatic pop();
    idle(); pop_en = 1'b1; cyc(); idle();
  endtask

  task automatic model_step(input logic p, input logic q, input logic c, input logic [12:0] d);
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (p && q) begin
      m_mem[(m_sp + 7) % 8] = d;
    end else if (p) begin
      m_mem[m_sp] = d;
      m_sp = (m_sp + 1) % 8;
      if (m_dep == 8) m_ovf = 1'b1; else m_dep++;
    end else if (q) begin
      m_sp = (m_sp + 7) % 8;
      if (m_dep == 0) m_unf = 1'b1; else m_dep--;
    end
  endtask

  initial begin
    idle();
    do_reset();
    check("reset_tos", 16'(tos_out), 16'h0);
    check("reset_depth", 16'(depth), 16'd0);
    check("reset_flags", 16'({ovf_flag, unf_flag}), 16'd0);

    // 1: basic push/pop
    push(13'h0123);
    push(13'h1ABC);
    check("t1_tos", 16'(tos_out), 16'h1ABC);
    check("t1_depth", 16'(depth), 16'd2);
    pop();
    check("t1_pop1_tos", 16'(tos_out), 16'h0123);
    check("t1_pop1_depth", 16'(depth), 16'd1);
    pop();
    check("t1_pop2_tos", 16'(tos_out), 16'h0);
    check("t1_pop2_depth", 16'(depth), 16'd0);
    check("t1_flags", 16'({ovf_flag, unf_flag}), 16'd0);

    // 2: overflow wrap then underflow
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push(13'(i));
      if (i == 8) check("t2_no_ovf_at_8", 16'(ovf_flag), 16'd0);
    end
    check("t2_depth", 16'(depth), 16'd8);
    check("t2_ovf", 16'(ovf_flag), 16'd1);
    check("t2_tos", 16'(tos_out), 16'h9);
    for (int i = 0; i < 8; i++) begin
      check("t2_pop_val", 16'(tos_out), (i == 0) ? 16'h9 : 16'(9 - i));
      pop();
    end
    check("t2_depth_empty", 16'(depth), 16'd0);
    check("t2_unf_not_yet", 16'(unf_flag), 16'd0);
    check("t2_pop9_val", 16'(tos_out), 16'h9);
    pop();
    check("t2_unf", 16'(unf_flag), 16'd1);
    check("t2_depth_after", 16'(depth), 16'd0);
    check("t2_tos_wrap", 16'(tos_out), 16'h8);

    // 3: push + pop replaces the top
    do_reset();
    push(13'h0100);
    idle(); push_en = 1'b1; pop_en = 1'b1; push_data = 13'h0200; cyc(); idle();
    check("t3_tos", 16'(tos_out), 16'h0200);
    check("t3_depth", 16'(depth), 16'd1);
    check("t3_flags", 16'({ovf_flag, unf_flag}), 16'd0);
    push(13'h0300);
    pop();
    check("t3_sp_unchanged", 16'(tos_out), 16'h0200);

    // 4: underflow and flag clear priority
    do_reset();
    pop();
    check("t4_unf", 16'(unf_flag), 16'd1);
    check("t4_depth", 16'(depth), 16'd0);
    idle(); flags_clr = 1'b1; cyc(); idle();
    check("t4_clr", 16'(unf_flag), 16'd0);
    idle(); flags_clr = 1'b1; pop_en = 1'b1; cyc(); idle();
    check("t4_set_wins", 16'(unf_flag), 16'd1);

    // 5: reset beats a simultaneous push
    do_reset();
    push(13'h0011); push(13'h0022); push(13'h0033);
    check("t5_depth_pre", 16'(depth), 16'd3);
    idle(); rst = 1'b1; push_en = 1'b1; push_data = 13'h0444; cyc(); idle();
    check("t5_depth", 16'(depth), 16'd0);
    check("t5_tos", 16'(tos_out), 16'h0);
    check("t5_flags", 16'({ovf_flag, unf_flag}), 16'd0);

    // 6: random sequence against the model
    do_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_sp = 0; m_dep = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      idle();
      push_en   = ($urandom_range(0, 99) < 50);
      pop_en    = ($urandom_range(0, 99) < 45);
      flags_clr = ($urandom_range(0, 99) < 5);
      push_data = 13'($urandom);
      model_step(push_en, pop_en, flags_clr, push_data);
      cyc();
      check("rnd_tos", 16'(tos_out), 16'(m_mem[(m_sp + 7) % 8]));
      check("rnd_depth", 16'(depth), 16'(m_dep));
      check("rnd_ovf", 16'(ovf_flag), 16'(m_ovf));
      check("rnd_unf", 16'(unf_flag), 16'(m_unf));
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
